// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc;

    logic              is_div, sgn_div, s1, s2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, ovf, fast;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   calc_res;
    logic              last;

    assign is_div   = op[2];
    assign sgn_div  = op[2] & ~op[0];
    assign s1       = is_div ? (sgn_div & rs1_data[XLEN-1])
                             : ((op == 3'd1 || op == 3'd2) & rs1_data[XLEN-1]);
    assign s2       = is_div ? (sgn_div & rs2_data[XLEN-1])
                             : ((op == 3'd1) & rs2_data[XLEN-1]);
    assign mag1     = s1 ? -rs1_data : rs1_data;
    assign mag2     = s2 ? -rs2_data : rs2_data;
    assign div_zero = is_div && (rs2_data == '0);
    assign ovf      = sgn_div
                   && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_data == '1);
    assign fast     = div_zero | ovf;

    always_comb begin
        fast_res = '0;
        unique case (1'b1)
            div_zero & ~op[1]: fast_res = '1;
            div_zero &  op[1]: fast_res = rs1_data;
            ovf & ~op[1]:      fast_res = {1'b1, {(XLEN-1){1'b0}}};
            default:           fast_res = '0;
        endcase
    end

    // acc holds {hi, lo}: product/multiplier for mul, remainder/quotient for div
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, opb_q} : '0);
    assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, opb_q};
    assign div_diff = div_sh[XLEN-1:0] - opb_q;

    always_comb begin
        if (op_q[2])
            acc_next = {div_ge ? div_diff : div_sh[XLEN-1:0],
                        acc[XLEN-2:0], div_ge};
        else
            acc_next = {mul_sum, acc[XLEN-1:1]};
    end

    assign prod_fix = neg_q ? -acc_next : acc_next;
    assign quo      = acc_next[XLEN-1:0];
    assign rem      = acc_next[2*XLEN-1:XLEN];

    always_comb begin
        if (op_q[2])
            calc_res = op_q[1] ? (rneg_q ? -rem : rem)
                               : (neg_q ? -quo : quo);
        else
            calc_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0]
                                           : prod_fix[2*XLEN-1:XLEN];
    end

    assign last  = (cnt == CNT_W'(XLEN-1));
    assign stall = (state == S_IDLE && start && !flush) || (state == S_CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            opb_q  <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q   <= op;
                        neg_q  <= s1 ^ s2;
                        rneg_q <= s1;
                        opb_q  <= is_div ? mag2 : mag1;
                        acc    <= {{XLEN{1'b0}}, is_div ? mag1 : mag2};
                        cnt    <= '0;
                        if (fast) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= fast_res;
                        end else begin
                            state <= S_CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            state  <= S_DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= calc_res;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
